// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode values,
// FSM state encoding and the datapath width of the shared ALU.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        RESP  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 16-bit ALU: purely combinational add/sub/and/or with a zero flag.
// Sub wraps modulo 2^16 and there is no carry or borrow output.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero
);

    // Select the operation; the zero flag always reflects the wrapped result
    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD: alu_result = a + b;
            ALU_SUB: alu_result = a - b;
            ALU_AND: alu_result = a & b;
            ALU_OR:  alu_result = a | b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter giving two requesters access to one shared ALU.
// Each operation takes three cycles (IDLE sample, GRANT compute, RESP report);
// operands are latched at grant so requesters cannot disturb an in-flight op.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [1:0]        op0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [1:0]        op1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              busy
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              grant_en;
    logic              grant_id;
    logic              ptr;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    alu_op_t           opnd_op;
    logic              opnd_id;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    // The one and only datapath, fed exclusively from the latched operands
    alu_arbiter_alu u_alu (
        .a          (opnd_a),
        .b          (opnd_b),
        .op         (opnd_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    // Next-state and arbitration decision; ptr names who wins a tie
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant_id = ptr;
                end else if (req1) begin
                    grant_id = 1'b1;
                end else begin
                    grant_id = 1'b0;
                end
                if (req0 || req1) begin
                    grant_en   = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's operands and advance the round-robin pointer on grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_a  <= '0;
            opnd_b  <= '0;
            opnd_op <= ALU_ADD;
            opnd_id <= 1'b0;
            ptr     <= 1'b0;
        end else if (grant_en) begin
            opnd_a  <= grant_id ? a1 : a0;
            opnd_b  <= grant_id ? b1 : b0;
            opnd_op <= alu_op_t'(grant_id ? op1 : op0);
            opnd_id <= grant_id;
            ptr     <= ~grant_id;
        end
    end

    // Capture the ALU output at the end of GRANT; it holds until the next op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
        end else if (state == GRANT) begin
            result <= alu_result;
            zero   <= alu_zero;
        end
    end

    // Registered status: done pulses for the single RESP cycle, busy tracks GRANT/RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done0 <= (state == GRANT) && (opnd_id == 1'b0);
            done1 <= (state == GRANT) && (opnd_id == 1'b1);
            busy  <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases with literal expectations
// followed by randomized traffic, all compared against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rq [2];
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic [1:0]  ro [2];
    logic        done0;
    logic        done1;
    logic [15:0] result;
    logic        zero;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    // Model state: cycles left in the current operation, who owns it,
    // the computed answer, the visible result/zero, and who wins the next tie
    int          mLeft    = 0;
    logic        mId      = 1'b0;
    logic [15:0] mPending = 16'h0;
    logic [15:0] mResult  = 16'h0;
    logic        mZero    = 1'b0;
    logic        mTie     = 1'b0;

    alu_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (rq[0]),
        .a0     (ra[0]),
        .b0     (rb[0]),
        .op0    (ro[0]),
        .req1   (rq[1]),
        .a1     (ra[1]),
        .b1     (rb[1]),
        .op1    (ro[1]),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .zero   (zero),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] aluCalc(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input logic r, input logic [15:0] a,
                                 input logic [15:0] b, input logic [1:0] op);
        rq[k] = r;
        ra[k] = a;
        rb[k] = b;
        ro[k] = op;
    endtask

    // Transaction model: an operation occupies three cycles, its answer
    // becomes visible on the second, and ties go to whoever was not served last
    always @(posedge clk) begin
        if (rst) begin
            mLeft   = 0;
            mResult = 16'h0;
            mZero   = 1'b0;
            mTie    = 1'b0;
            mId     = 1'b0;
        end else if (mLeft == 2) begin
            mLeft   = 1;
            mResult = mPending;
            mZero   = (mPending == 16'h0);
        end else if (mLeft == 1) begin
            mLeft = 0;
        end else if (rq[0] || rq[1]) begin
            mId      = (rq[0] && rq[1]) ? mTie : rq[1];
            mPending = aluCalc(ro[mId], ra[mId], rb[mId]);
            mTie     = ~mId;
            mLeft    = 2;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_done0",  16'(done0),  16'(mLeft == 1 && mId == 1'b0));
            checkOutput("cyc_done1",  16'(done1),  16'(mLeft == 1 && mId == 1'b1));
            checkOutput("cyc_busy",   16'(busy),   16'(mLeft != 0));
            checkOutput("cyc_result", result,      mResult);
            checkOutput("cyc_zero",   16'(zero),   16'(mZero));
        end
    end

    // Random requester behaviour: raise requests at random, sometimes keep
    // req high after done, disturb operands of an in-flight op, rare resets
    task automatic randomStep();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] na;
            na = 16'($urandom);
            if (rq[k] && mLeft == 1 && mId == k[0]) begin
                if ($urandom_range(0, 1) == 0)
                    applyStimulus(k, 1'b0, ra[k], rb[k], ro[k]);
                else
                    applyStimulus(k, 1'b1, na, ($urandom_range(0, 3) == 0) ? na : 16'($urandom),
                                  2'($urandom_range(0, 3)));
            end else if (!rq[k]) begin
                if ($urandom_range(0, 2) == 0)
                    applyStimulus(k, 1'b1, na, ($urandom_range(0, 3) == 0) ? na : 16'($urandom),
                                  2'($urandom_range(0, 3)));
            end else if (mLeft == 2 && mId == k[0] && $urandom_range(0, 1) == 0) begin
                applyStimulus(k, 1'b1, na, 16'($urandom), 2'($urandom_range(0, 3)));
            end
        end
        if (rst)
            rst = 1'b0;
        else if ($urandom_range(0, 299) == 0)
            rst = 1'b1;
    endtask

    // Directed scenarios with literal expectations, then random traffic
    initial begin
        applyStimulus(0, 1'b0, 16'h0, 16'h0, 2'd0);
        applyStimulus(1, 1'b0, 16'h0, 16'h0, 2'd0);
        checkEn = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_busy",   16'(busy),  16'd0);
        checkOutput("rst_result", result,     16'h0000);
        checkOutput("rst_zero",   16'(zero),  16'd0);
        checkOutput("rst_done",   16'({done1, done0}), 16'd0);

        // Single add on requester 0
        #2 applyStimulus(0, 1'b1, 16'd5, 16'd3, 2'd0);
        @(negedge clk);
        checkOutput("add_grant_busy",  16'(busy),  16'd1);
        checkOutput("add_grant_done0", 16'(done0), 16'd0);
        @(negedge clk);
        checkOutput("add_done0",  16'(done0), 16'd1);
        checkOutput("add_done1",  16'(done1), 16'd0);
        checkOutput("add_result", result,     16'd8);
        checkOutput("add_zero",   16'(zero),  16'd0);
        #2 applyStimulus(0, 1'b0, 16'd5, 16'd3, 2'd0);
        @(negedge clk);
        checkOutput("add_idle_done0",  16'(done0), 16'd0);
        checkOutput("add_idle_busy",   16'(busy),  16'd0);
        checkOutput("add_hold_result", result,     16'd8);

        // Single sub on requester 1 yielding zero
        #2 applyStimulus(1, 1'b1, 16'd7, 16'd7, 2'd1);
        repeat (2) @(negedge clk);
        checkOutput("sub_done1",  16'(done1), 16'd1);
        checkOutput("sub_result", result,     16'h0000);
        checkOutput("sub_zero",   16'(zero),  16'd1);
        #2 applyStimulus(1, 1'b0, 16'd7, 16'd7, 2'd1);
        @(negedge clk);

        // Fresh reset, then both requesters held: service alternates 0,1,0,1
        #2 rst = 1'b1;
        #1 checkOutput("rst2_result", result, 16'h0000);
        @(negedge clk);
        #2 rst = 1'b0;
        applyStimulus(0, 1'b1, 16'hFFFF, 16'h00F0, 2'd2);
        applyStimulus(1, 1'b1, 16'h0F00, 16'h00F0, 2'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            @(negedge clk);
            checkOutput($sformatf("rr%0d_done0", i), 16'(done0), 16'(i % 2 == 0));
            checkOutput($sformatf("rr%0d_done1", i), 16'(done1), 16'(i % 2 == 1));
            checkOutput($sformatf("rr%0d_result", i), result, (i % 2 == 0) ? 16'h00F0 : 16'h0FF0);
            @(negedge clk);
        end
        #2 applyStimulus(0, 1'b0, 16'h0, 16'h0, 2'd0);
        applyStimulus(1, 1'b0, 16'h0, 16'h0, 2'd0);
        @(negedge clk);

        // Subtraction wrap-around
        #2 applyStimulus(0, 1'b1, 16'h0000, 16'h0001, 2'd1);
        repeat (2) @(negedge clk);
        checkOutput("wrap_result", result,    16'hFFFF);
        checkOutput("wrap_zero",   16'(zero), 16'd0);
        #2 applyStimulus(0, 1'b0, 16'h0, 16'h0, 2'd0);
        @(negedge clk);

        // Operands changed after grant must not affect the in-flight op
        #2 applyStimulus(0, 1'b1, 16'h1234, 16'h0011, 2'd0);
        @(negedge clk);
        #2 applyStimulus(0, 1'b1, 16'hFFFF, 16'h0011, 2'd2);
        @(negedge clk);
        checkOutput("latch_result", result, 16'h1245);
        #2 applyStimulus(0, 1'b0, 16'h0, 16'h0, 2'd0);
        @(negedge clk);

        // Reset during GRANT aborts; held request completes after release
        #2 applyStimulus(0, 1'b1, 16'd5, 16'd3, 2'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy",   16'(busy),  16'd0);
        checkOutput("abort_result", result,     16'h0000);
        checkOutput("abort_done0",  16'(done0), 16'd0);
        @(negedge clk);
        checkOutput("abort_nodone", 16'(done0), 16'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("retry_busy", 16'(busy), 16'd1);
        @(negedge clk);
        checkOutput("retry_done0",  16'(done0), 16'd1);
        checkOutput("retry_result", result,     16'd8);
        #2 applyStimulus(0, 1'b0, 16'd5, 16'd3, 2'd0);
        @(negedge clk);

        // Randomized traffic checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #2 randomStep();
        end
        rst = 1'b0;
        applyStimulus(0, 1'b0, 16'h0, 16'h0, 2'd0);
        applyStimulus(1, 1'b0, 16'h0, 16'h0, 2'd0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
